led_frame_sequencer: RTL and testbench

//  Frame-level controller for the two-wire serial LED strip (clock + data, 32-bit words, MSB first).

---
 rtl/led_strip_pkg.sv | 18 +
 rtl/strip_serializer.sv | 71 +++++++
 rtl/led_frame_sequencer.sv | 133 +++++++++++++
 tb/tb_led_frame_sequencer.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_strip_pkg.sv
// Shared types and constants for the LED strip frame sequencer.
// State encoding plus strip word geometry.
package led_strip_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_FETCH,
    S_SHIFT,
    S_END,
    S_HOLD
  } state_t;

  localparam int START_BITS = 32;
  localparam int WORD_BITS  = 32;
  localparam logic [2:0] LED_HDR = 3'b111;

endpackage

// File: rtl/strip_serializer.sv
// Shifts up to 255 bits MSB first onto the strip clock/data pins.
// Bits past the loaded word are zero; data moves only while strip_clk is low.
import led_strip_pkg::*;

module strip_serializer #(
  parameter int CLK_DIV = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [WORD_BITS-1:0] word,
  input  logic [7:0]           nbits,
  output logic                 busy,
  output logic                 done,
  output logic                 strip_clk,
  output logic                 strip_data
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [WORD_BITS-1:0] sh;
  logic [7:0]           rem;
  logic [DW-1:0]        div;
  logic                 phase_end;

  assign phase_end = (div == DW'(CLK_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      sh         <= '0;
      rem        <= '0;
      div        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      strip_clk  <= 1'b0;
      strip_data <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load && !busy) begin
        sh         <= word;
        rem        <= nbits;
        div        <= '0;
        busy       <= 1'b1;
        strip_clk  <= 1'b0;
        strip_data <= word[WORD_BITS-1];
      end else if (busy) begin
        if (!phase_end) begin
          div <= div + 1'b1;
        end else begin
          div <= '0;
          if (!strip_clk) begin
            strip_clk <= 1'b1;
          end else begin
            // falling edge closes the bit; next bit appears in the low phase
            strip_clk <= 1'b0;
            sh        <= sh << 1;
            rem       <= rem - 8'd1;
            if (rem == 8'd1) begin
              busy       <= 1'b0;
              done       <= 1'b1;
              strip_data <= 1'b0;
            end else begin
              strip_data <= sh[WORD_BITS-2];
            end
          end
        end
      end
    end
  end

endmodule

// File: rtl/led_frame_sequencer.sv
// Frame controller: start frame, per-LED fetch and shift, end frame, hold.
// Advances the character index once per completed frame.
import led_strip_pkg::*;

module led_frame_sequencer #(
  parameter int NUM_LEDS    = 64,
  parameter int NUM_CHARS   = 4,
  parameter int CLK_DIV     = 1,
  parameter int END_BITS    = 64,
  parameter int HOLD_CYCLES = 1000,
  localparam int IW = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1,
  localparam int CW = (NUM_CHARS > 1) ? $clog2(NUM_CHARS) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  output logic          pix_req,
  output logic [IW-1:0] pix_idx,
  output logic [CW-1:0] pix_char,
  input  logic [31:0]   pix_word,
  input  logic          pix_valid,
  output logic          strip_clk,
  output logic          strip_data,
  output logic          frame_busy,
  output logic          frame_done,
  output logic [CW-1:0] char_idx
);

  localparam int HW = $clog2(HOLD_CYCLES + 1);

  state_t        state;
  state_t        next_state;
  logic [HW-1:0] hold_cnt;
  logic          ld;
  logic [31:0]   ld_word;
  logic [7:0]    ld_bits;
  logic          ser_busy;
  logic          ser_done;
  logic          last_led;
  logic          hold_end;

  assign last_led = (pix_idx == IW'(NUM_LEDS - 1));
  assign hold_end = (hold_cnt == HW'(HOLD_CYCLES - 1));
  assign pix_char = char_idx;

  always_comb begin
    next_state = state;
    ld         = 1'b0;
    ld_word    = '0;
    ld_bits    = 8'(START_BITS);
    unique case (state)
      S_IDLE: begin
        if (enable && !ser_busy) begin
          next_state = S_START;
          ld         = 1'b1;
        end
      end
      S_START: begin
        if (ser_done) next_state = S_FETCH;
      end
      S_FETCH: begin
        if (pix_valid) begin
          next_state = S_SHIFT;
          ld         = 1'b1;
          ld_word    = pix_word;
          ld_bits    = 8'(WORD_BITS);
        end
      end
      S_SHIFT: begin
        if (ser_done) begin
          if (last_led) begin
            next_state = S_END;
            ld         = 1'b1;
            ld_bits    = 8'(END_BITS);
          end else begin
            next_state = S_FETCH;
          end
        end
      end
      S_END: begin
        if (ser_done) next_state = S_HOLD;
      end
      S_HOLD: begin
        if (hold_end) begin
          if (enable) begin
            next_state = S_START;
            ld         = 1'b1;
          end else begin
            next_state = S_IDLE;
          end
        end
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      pix_req    <= 1'b0;
      pix_idx    <= '0;
      char_idx   <= '0;
      frame_busy <= 1'b0;
      frame_done <= 1'b0;
      hold_cnt   <= '0;
    end else begin
      state      <= next_state;
      pix_req    <= (next_state == S_FETCH);
      frame_busy <= (next_state != S_IDLE);
      frame_done <= (state == S_END) && ser_done;
      hold_cnt   <= (state == S_HOLD) ? hold_cnt + 1'b1 : '0;
      if (state == S_SHIFT && ser_done)
        pix_idx <= last_led ? '0 : pix_idx + 1'b1;
      if (state == S_END && ser_done)
        char_idx <= (char_idx == CW'(NUM_CHARS - 1)) ? '0 : char_idx + 1'b1;
    end
  end

  strip_serializer #(
    .CLK_DIV(CLK_DIV)
  ) u_ser (
    .clk       (clk),
    .rst       (rst),
    .load      (ld),
    .word      (ld_word),
    .nbits     (ld_bits),
    .busy      (ser_busy),
    .done      (ser_done),
    .strip_clk (strip_clk),
    .strip_data(strip_data)
  );

endmodule

// File: tb/tb_led_frame_sequencer.sv
// Randomised bench for led_frame_sequencer with a frame-level bit-stream model.
// A negedge pixel source records accepted words; expected strip streams are built from them.
module tb_led_frame_sequencer;
  import led_strip_pkg::*;

  localparam int NL = 2;
  localparam int NC = 4;
  localparam int EB = 8;
  localparam int HC = 4;
  localparam int FRAME_BITS = START_BITS + NL * WORD_BITS + EB;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        pix_valid = 1'b0;
  logic [31:0] pix_word = '0;
  logic        pix_req;
  logic [0:0]  pix_idx;
  logic [1:0]  pix_char;
  logic        strip_clk;
  logic        strip_data;
  logic        frame_busy;
  logic        frame_done;
  logic [1:0]  char_idx;

  always #5 clk = ~clk;

  led_frame_sequencer #(
    .NUM_LEDS(NL), .NUM_CHARS(NC), .CLK_DIV(1),
    .END_BITS(EB), .HOLD_CYCLES(HC)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .pix_req(pix_req), .pix_idx(pix_idx), .pix_char(pix_char),
    .pix_word(pix_word), .pix_valid(pix_valid),
    .strip_clk(strip_clk), .strip_data(strip_data),
    .frame_busy(frame_busy), .frame_done(frame_done),
    .char_idx(char_idx)
  );

  int checks = 0;
  int errors = 0;

  bit          bits_q[$];
  logic [31:0] words_q[$];
  int          idx_q[$];
  int          pchar_q[$];
  int          done_chars_q[$];
  int          rises = 0;
  int          done_cnt = 0;
  int          hold_len = 0;
  bit          in_hold = 0;
  bit          fixed_mode = 0;
  logic [31:0] fixed_word = 32'hFF0000FF;
  int          stall_led = -1;
  int          stall_left = 0;
  logic        prev_clk = 1'b0;

  // strip monitor plus pixel source, both on the falling clk edge
  initial begin
    forever begin
      @(negedge clk);
      if (strip_clk && !prev_clk) begin
        bits_q.push_back(strip_data);
        rises++;
      end
      prev_clk = strip_clk;
      if (frame_done) begin
        done_cnt++;
        done_chars_q.push_back(int'(char_idx));
        hold_len = 0;
        in_hold = 1;
      end
      if (in_hold) begin
        if (frame_busy) hold_len++;
        else in_hold = 0;
      end
      if (pix_req && stall_led == int'(pix_idx) && stall_left > 0) begin
        pix_valid = 1'b0;
        stall_left--;
        checks++;
        if (strip_clk !== 1'b0 || strip_data !== 1'b0 || frame_busy !== 1'b1) begin
          errors++;
          $display("FAIL stall_quiet: clk=%b data=%b busy=%b required 0 0 1",
                   strip_clk, strip_data, frame_busy);
        end
      end else begin
        pix_valid = fixed_mode ? 1'b1 : ($urandom_range(0, 3) != 0);
        pix_word = fixed_mode ? fixed_word
                              : {LED_HDR, 5'($urandom), 24'($urandom)};
      end
      if (pix_req && pix_valid) begin
        words_q.push_back(pix_word);
        idx_q.push_back(int'(pix_idx));
        pchar_q.push_back(int'(pix_char));
      end
    end
  end

  task automatic clear_obs();
    bits_q.delete();
    words_q.delete();
    idx_q.delete();
    pchar_q.delete();
    done_chars_q.delete();
    rises = 0;
    done_cnt = 0;
  endtask

  task automatic wait_busy(input string name, input int limit);
    int c = 0;
    while (frame_busy !== 1'b1 && c < limit) begin
      @(negedge clk);
      c++;
    end
    checks++;
    if (frame_busy !== 1'b1) begin
      errors++;
      $display("FAIL %s_start_timeout: frame_busy=%b required 1", name, frame_busy);
    end
  endtask

  task automatic wait_frames(input string name, input int n, input int limit);
    int c = 0;
    while (done_cnt < n && c < limit) begin
      @(negedge clk);
      c++;
    end
    checks++;
    if (done_cnt < n) begin
      errors++;
      $display("FAIL %s_done_timeout: frames=%0d required %0d", name, done_cnt, n);
    end
  endtask

  task automatic wait_idle(input string name, input int limit);
    int c = 0;
    while (frame_busy !== 1'b0 && c < limit) begin
      @(negedge clk);
      c++;
    end
    checks++;
    if (frame_busy !== 1'b0 || strip_clk !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle: busy=%b clk=%b required 0 0", name, frame_busy, strip_clk);
    end
  endtask

  task automatic wait_words(input string name, input int n, input int limit);
    int c = 0;
    while (words_q.size() < n && c < limit) begin
      @(negedge clk);
      c++;
    end
    checks++;
    if (words_q.size() < n) begin
      errors++;
      $display("FAIL %s_fetch_timeout: words=%0d required %0d", name, words_q.size(), n);
    end
  endtask

  // expected strip stream: per frame 32 zeros, accepted words MSB first, EB zeros
  task automatic check_stream(input string name, input int nf);
    bit exp_q[$];
    int bad = -1;
    logic [31:0] w;
    checks++;
    if (words_q.size() < nf * NL) begin
      errors++;
      $display("FAIL %s_words: accepted=%0d required %0d", name, words_q.size(), nf * NL);
      return;
    end
    for (int f = 0; f < nf; f++) begin
      for (int i = 0; i < START_BITS; i++) exp_q.push_back(1'b0);
      for (int k = 0; k < NL; k++) begin
        w = words_q[f * NL + k];
        for (int b = 31; b >= 0; b--) exp_q.push_back(w[b]);
      end
      for (int i = 0; i < EB; i++) exp_q.push_back(1'b0);
    end
    if (bits_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL %s_stream_len: bits=%0d required %0d", name, bits_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) if (bad < 0 && bits_q[i] !== exp_q[i]) bad = i;
      if (bad >= 0) begin
        errors++;
        $display("FAIL %s_stream: bit %0d is %b required %b", name, bad, bits_q[bad], exp_q[bad]);
      end
    end
  endtask

  task automatic check_meta(input string name, input int nf, input int char0);
    int bad = -1;
    checks++;
    if (idx_q.size() < nf * NL) begin
      errors++;
      $display("FAIL %s_meta_count: fetches=%0d required %0d", name, idx_q.size(), nf * NL);
      return;
    end
    for (int k = 0; k < nf * NL; k++)
      if (bad < 0 && (idx_q[k] != k % NL || pchar_q[k] != (char0 + k / NL) % NC)) bad = k;
    if (bad >= 0) begin
      errors++;
      $display("FAIL %s_meta: fetch %0d idx=%0d char=%0d required idx=%0d char=%0d", name, bad,
               idx_q[bad], pchar_q[bad], bad % NL, (char0 + bad / NL) % NC);
    end
  endtask

  task automatic check_outputs_zero(input string name);
    checks++;
    if ({pix_req, pix_idx, pix_char, strip_clk, strip_data,
         frame_busy, frame_done, char_idx} !== '0) begin
      errors++;
      $display("FAIL %s_outputs: req=%b idx=%0d pchar=%0d sclk=%b sdata=%b busy=%b done=%b char=%0d required all 0",
               name, pix_req, pix_idx, pix_char, strip_clk, strip_data,
               frame_busy, frame_done, char_idx);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    enable = 1'b1;
    clear_obs();
    repeat (2) @(negedge clk);
    check_outputs_zero("reset");
    checks++;
    if (rises !== 0) begin
      errors++;
      $display("FAIL reset_edges: rises=%0d required 0", rises);
    end
    enable = 1'b0;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_one_frame();
    fixed_mode = 1;
    clear_obs();
    enable = 1'b1;
    wait_busy("one", 10);
    enable = 1'b0;
    wait_frames("one", 1, 2000);
    wait_idle("one", 50);
    check_stream("one", 1);
    check_meta("one", 1, 0);
    checks++;
    if (rises !== FRAME_BITS || words_q[0] !== 32'hFF0000FF) begin
      errors++;
      $display("FAIL one_edges: rises=%0d word0=%h required %0d FF0000FF",
               rises, words_q[0], FRAME_BITS);
    end
    checks++;
    if (done_cnt !== 1 || char_idx !== 2'd1) begin
      errors++;
      $display("FAIL one_done: done=%0d char=%0d required 1 1", done_cnt, char_idx);
    end
    fixed_mode = 0;
  endtask

  task automatic test_stall();
    clear_obs();
    stall_led = 1;
    stall_left = 10;
    enable = 1'b1;
    wait_busy("stall", 10);
    enable = 1'b0;
    wait_frames("stall", 1, 2000);
    wait_idle("stall", 50);
    checks++;
    if (stall_left !== 0) begin
      errors++;
      $display("FAIL stall_applied: remaining=%0d required 0", stall_left);
    end
    stall_led = -1;
    check_stream("stall", 1);
    check_meta("stall", 1, 1);
  endtask

  task automatic test_enable_drop();
    clear_obs();
    enable = 1'b1;
    wait_words("drop", 1, 500);
    repeat (3) @(negedge clk);
    enable = 1'b0;
    checks++;
    if (frame_busy !== 1'b1) begin
      errors++;
      $display("FAIL drop_midframe: busy=%b required 1", frame_busy);
    end
    wait_frames("drop", 1, 2000);
    wait_idle("drop", 50);
    checks++;
    if (hold_len !== HC) begin
      errors++;
      $display("FAIL drop_hold: busy cycles after done=%0d required %0d", hold_len, HC);
    end
    repeat (20) @(negedge clk);
    checks++;
    if (rises !== FRAME_BITS || frame_busy !== 1'b0 || done_cnt !== 1) begin
      errors++;
      $display("FAIL drop_single: rises=%0d busy=%b done=%0d required %0d 0 1",
               rises, frame_busy, done_cnt, FRAME_BITS);
    end
    check_stream("drop", 1);
    check_meta("drop", 1, 2);
  endtask

  task automatic test_back_to_back();
    int exp_c;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    clear_obs();
    enable = 1'b1;
    wait_frames("b2b", 5, 6000);
    enable = 1'b0;
    wait_idle("b2b", 50);
    for (int f = 0; f < 5; f++) begin
      exp_c = (f + 1) % NC;
      checks++;
      if (done_chars_q.size() <= f || done_chars_q[f] !== exp_c) begin
        errors++;
        $display("FAIL b2b_char%0d: char_idx=%0d required %0d", f,
                 (done_chars_q.size() > f) ? done_chars_q[f] : -1, exp_c);
      end
    end
    check_stream("b2b", 5);
    check_meta("b2b", 5, 0);
  endtask

  task automatic test_reset_mid();
    clear_obs();
    enable = 1'b1;
    wait_words("rmid", 2, 1000);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_outputs_zero("rmid");
    rst = 1'b0;
    clear_obs();
    wait_frames("rmid", 1, 2000);
    enable = 1'b0;
    wait_idle("rmid", 50);
    check_stream("rmid", 1);
    check_meta("rmid", 1, 0);
    checks++;
    if (rises !== FRAME_BITS || char_idx !== 2'd1) begin
      errors++;
      $display("FAIL rmid_frame: rises=%0d char=%0d required %0d 1", rises, char_idx, FRAME_BITS);
    end
  endtask

  initial begin
    test_reset();
    test_one_frame();
    test_stall();
    test_enable_drop();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
